// File: rtl/pkt_framing_checker.sv
// -----------------------------------------------------------------------------
// pkt_framing_checker
//   Ingress framing checker/sanitiser for a raw 32-bit beat stream that has no
//   backpressure. Enforces SOP..EOP framing so the downstream 32->64 packet
//   translator only ever sees well-formed packets:
//     - orphan beats (no packet open) are dropped,
//     - a SOP inside an open packet closes that packet as bad,
//     - packets longer than MAX_PKT_BYTES are truncated and closed as bad,
//     - runts (< MIN_PKT_BYTES) and PHY errors are flagged via obad on EOP.
//   Every input beat produces its result exactly one iclk later.
//
// Parameters
//   DATA_WIDTH     beat width, fixed at 32 (4 bytes per beat)
//   MAX_PKT_BYTES  largest legal packet in bytes (<= 16380)
//   MIN_PKT_BYTES  smallest legal packet in bytes (>= 4)
//
// Ports
//   iclk, irst               clock; asynchronous active-high reset
//   in_valid/in_sop/in_eop   input beat qualifiers (no ready: all beats consumed)
//   in_residual              valid bytes on EOP beat (0 means 4)
//   in_data, in_err          beat data (byte 0 in [31:24]); PHY error flag
//   ovalid/osop/oeop         output beat qualifiers
//   oresidual, odata         output residual (EOP only) and data
//   obad                     packet bad, qualified on the oeop beat
//   err_*                    single-cycle error pulses
//   stat_pkt_cnt/stat_bad_cnt  saturating counts of emitted / bad packets
// -----------------------------------------------------------------------------
module pkt_framing_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_PKT_BYTES = 9600,
  parameter int MIN_PKT_BYTES = 64
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [1:0]            in_residual,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  ovalid,
  output logic                  osop,
  output logic                  oeop,
  output logic [1:0]            oresidual,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  obad,
  output logic                  err_no_sop,
  output logic                  err_sop_in_pkt,
  output logic                  err_oversize,
  output logic                  err_runt,
  output logic [15:0]           stat_pkt_cnt,
  output logic [15:0]           stat_bad_cnt
);

  localparam logic [13:0] MAX_LEN = 14'(MAX_PKT_BYTES);
  localparam logic [13:0] MIN_LEN = 14'(MIN_PKT_BYTES);

  // IDLE: no packet open. PKT: packet open and being forwarded.
  // DISCARD: dropping the tail of a killed or orphan packet until EOP.
  typedef enum logic [1:0] {
    IDLE,
    PKT,
    DISCARD
  } state_t;

  state_t                  state, state_nxt;
  logic [13:0]             len, len_nxt;
  logic                    sticky_bad, sticky_bad_nxt;

  logic [13:0]             beat_bytes;
  logic [14:0]             len_wide;
  logic [13:0]             len_sum;
  logic                    over_max;

  logic                    ovalid_nxt, osop_nxt, oeop_nxt, obad_nxt;
  logic [1:0]              oresidual_nxt;
  logic [DATA_WIDTH-1:0]   odata_nxt;
  logic                    err_no_sop_nxt, err_sop_in_pkt_nxt;
  logic                    err_oversize_nxt, err_runt_nxt;

  // Running length including the current beat, saturating at 14 bits.
  assign beat_bytes = (in_eop && (in_residual != 2'd0)) ? {12'd0, in_residual} : 14'd4;
  assign len_wide   = {1'b0, len} + {1'b0, beat_bytes};
  assign len_sum    = len_wide[14] ? 14'h3FFF : len_wide[13:0];
  assign over_max   = (len_sum > MAX_LEN);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt          = state;
    len_nxt            = len;
    sticky_bad_nxt     = sticky_bad;
    ovalid_nxt         = 1'b0;
    osop_nxt           = 1'b0;
    oeop_nxt           = 1'b0;
    oresidual_nxt      = 2'd0;
    odata_nxt          = '0;
    obad_nxt           = 1'b0;
    err_no_sop_nxt     = 1'b0;
    err_sop_in_pkt_nxt = 1'b0;
    err_oversize_nxt   = 1'b0;
    err_runt_nxt       = 1'b0;

    if (in_valid) begin
      case (state)
        IDLE, DISCARD: begin
          if (in_sop) begin
            ovalid_nxt = 1'b1;
            osop_nxt   = 1'b1;
            odata_nxt  = in_data;
            if (in_eop) begin
              // Single-beat packet: opens and closes on the same beat.
              oeop_nxt       = 1'b1;
              oresidual_nxt  = in_residual;
              err_runt_nxt   = (beat_bytes < MIN_LEN);
              obad_nxt       = in_err | err_runt_nxt;
              len_nxt        = 14'd0;
              sticky_bad_nxt = 1'b0;
              state_nxt      = IDLE;
            end else begin
              len_nxt        = 14'd4;
              sticky_bad_nxt = in_err;
              state_nxt      = PKT;
            end
          end else begin
            // Only the first orphan beat is reported; the rest of a
            // discarded packet is dropped silently.
            err_no_sop_nxt = (state == IDLE);
            state_nxt      = in_eop ? IDLE : DISCARD;
          end
        end

        PKT: begin
          ovalid_nxt = 1'b1;
          odata_nxt  = in_data;
          if (in_sop || over_max) begin
            // Forced close: the current beat becomes a bad EOP and anything
            // left of the input packet is discarded.
            oeop_nxt           = 1'b1;
            obad_nxt           = 1'b1;
            err_sop_in_pkt_nxt = in_sop;
            err_oversize_nxt   = over_max;
            len_nxt            = 14'd0;
            sticky_bad_nxt     = 1'b0;
            state_nxt          = in_eop ? IDLE : DISCARD;
          end else if (in_eop) begin
            oeop_nxt       = 1'b1;
            oresidual_nxt  = in_residual;
            err_runt_nxt   = (len_sum < MIN_LEN);
            obad_nxt       = sticky_bad | in_err | err_runt_nxt;
            len_nxt        = 14'd0;
            sticky_bad_nxt = 1'b0;
            state_nxt      = IDLE;
          end else begin
            len_nxt        = len_sum;
            sticky_bad_nxt = sticky_bad | in_err;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state          <= IDLE;
      len            <= 14'd0;
      sticky_bad     <= 1'b0;
      ovalid         <= 1'b0;
      osop           <= 1'b0;
      oeop           <= 1'b0;
      oresidual      <= 2'd0;
      odata          <= '0;
      obad           <= 1'b0;
      err_no_sop     <= 1'b0;
      err_sop_in_pkt <= 1'b0;
      err_oversize   <= 1'b0;
      err_runt       <= 1'b0;
      stat_pkt_cnt   <= 16'd0;
      stat_bad_cnt   <= 16'd0;
    end else begin
      state          <= state_nxt;
      len            <= len_nxt;
      sticky_bad     <= sticky_bad_nxt;
      ovalid         <= ovalid_nxt;
      osop           <= osop_nxt;
      oeop           <= oeop_nxt;
      oresidual      <= oresidual_nxt;
      odata          <= odata_nxt;
      obad           <= obad_nxt;
      err_no_sop     <= err_no_sop_nxt;
      err_sop_in_pkt <= err_sop_in_pkt_nxt;
      err_oversize   <= err_oversize_nxt;
      err_runt       <= err_runt_nxt;
      // Counters saturate rather than wrap.
      if (oeop_nxt && (stat_pkt_cnt != 16'hFFFF)) begin
        stat_pkt_cnt <= stat_pkt_cnt + 16'd1;
      end
      if (oeop_nxt && obad_nxt && (stat_bad_cnt != 16'hFFFF)) begin
        stat_bad_cnt <= stat_bad_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_framing_checker.sv
// -----------------------------------------------------------------------------
// tb_pkt_framing_checker
//   Two instances share one stimulus stream: u0 with default limits
//   (MAX 9600, MIN 64) and u1 with MAX 64 / MIN 64 so truncation is reachable
//   with short packets. A packet-level model predicts every output of both
//   instances each cycle; directed tests add literal expectations on beat
//   counts, error pulses and statistics.
// -----------------------------------------------------------------------------
module tb_pkt_framing_checker;

  // Observed/expected output bundle.
  typedef struct packed {
    logic        v, s, e;
    logic [1:0]  r;
    logic [31:0] d;
    logic        b, ens, esip, eov, ert;
    logic [15:0] pc, bc;
  } obs_t;

  // Model state: is a packet open, are we skipping to an EOP, byte count.
  typedef struct packed {
    logic open;
    logic skip;
    logic bad;
    int   len;
  } mstate_t;

  typedef struct packed {
    mstate_t s;
    obs_t    o;
  } mres_t;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [1:0]  in_residual = 2'd0;
  logic [31:0] in_data = 32'd0;

  logic        ovalid[2], osop[2], oeop[2], obad[2];
  logic [1:0]  oresidual[2];
  logic [31:0] odata[2];
  logic        err_no_sop[2], err_sop_in_pkt[2], err_oversize[2], err_runt[2];
  logic [15:0] stat_pkt_cnt[2], stat_bad_cnt[2];

  obs_t  act[2];
  mres_t mr[2];

  int n_checks = 0;
  int n_pass   = 0;

  // Event counters per instance, updated by the compare process.
  int n_out[2], n_ns[2], n_sip[2], n_ov[2], n_rt[2], n_bp[2];
  int s_out[2], s_ns[2], s_sip[2], s_ov[2], s_rt[2], s_bp[2];

  always #5 iclk = ~iclk;

  pkt_framing_checker u0 (
    .iclk(iclk), .irst(irst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_residual(in_residual), .in_data(in_data), .in_err(in_err),
    .ovalid(ovalid[0]), .osop(osop[0]), .oeop(oeop[0]), .oresidual(oresidual[0]),
    .odata(odata[0]), .obad(obad[0]), .err_no_sop(err_no_sop[0]),
    .err_sop_in_pkt(err_sop_in_pkt[0]), .err_oversize(err_oversize[0]),
    .err_runt(err_runt[0]), .stat_pkt_cnt(stat_pkt_cnt[0]), .stat_bad_cnt(stat_bad_cnt[0])
  );

  pkt_framing_checker #(.MAX_PKT_BYTES(64), .MIN_PKT_BYTES(64)) u1 (
    .iclk(iclk), .irst(irst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_residual(in_residual), .in_data(in_data), .in_err(in_err),
    .ovalid(ovalid[1]), .osop(osop[1]), .oeop(oeop[1]), .oresidual(oresidual[1]),
    .odata(odata[1]), .obad(obad[1]), .err_no_sop(err_no_sop[1]),
    .err_sop_in_pkt(err_sop_in_pkt[1]), .err_oversize(err_oversize[1]),
    .err_runt(err_runt[1]), .stat_pkt_cnt(stat_pkt_cnt[1]), .stat_bad_cnt(stat_bad_cnt[1])
  );

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      act[i] = {ovalid[i], osop[i], oeop[i], oresidual[i], odata[i], obad[i],
                err_no_sop[i], err_sop_in_pkt[i], err_oversize[i], err_runt[i],
                stat_pkt_cnt[i], stat_bad_cnt[i]};
    end
  end

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Packet-level reference: what one input beat must produce, given whether a
  // packet is open and how many bytes it already holds.
  function automatic mres_t model_beat(mstate_t s, obs_t prev, int maxb, int minb);
    mres_t r;
    int    bytes;
    int    total;
    r      = '0;
    r.s    = s;
    r.o.pc = prev.pc;
    r.o.bc = prev.bc;
    if (!in_valid) return r;
    bytes = (in_eop && in_residual != 2'd0) ? int'(in_residual) : 4;
    if (!s.open) begin
      if (in_sop) begin
        r.o.v = 1'b1; r.o.s = 1'b1; r.o.d = in_data; r.s.skip = 1'b0;
        if (in_eop) begin
          r.o.e = 1'b1; r.o.r = in_residual;
          r.o.ert = (bytes < minb);
          r.o.b = in_err || (bytes < minb);
        end else begin
          r.s.open = 1'b1; r.s.len = bytes; r.s.bad = in_err;
        end
      end else begin
        r.o.ens  = !s.skip;
        r.s.skip = !in_eop;
      end
    end else begin
      total = s.len + bytes;
      r.o.v = 1'b1; r.o.d = in_data;
      if (in_sop || total > maxb) begin
        r.o.e = 1'b1; r.o.b = 1'b1;
        r.o.esip = in_sop; r.o.eov = (total > maxb);
        r.s.open = 1'b0; r.s.skip = !in_eop;
      end else if (in_eop) begin
        r.o.e = 1'b1; r.o.r = in_residual;
        r.o.ert = (total < minb);
        r.o.b = s.bad || in_err || (total < minb);
        r.s.open = 1'b0;
      end else begin
        r.s.len = total;
        r.s.bad = s.bad || in_err;
      end
    end
    if (r.o.e) begin
      if (r.o.pc != 16'hFFFF) r.o.pc = r.o.pc + 16'd1;
      if (r.o.b && r.o.bc != 16'hFFFF) r.o.bc = r.o.bc + 16'd1;
    end
    return r;
  endfunction

  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      mr[0] <= '0;
      mr[1] <= '0;
    end else begin
      mr[0] <= model_beat(mr[0].s, mr[0].o, 9600, 64);
      mr[1] <= model_beat(mr[1].s, mr[1].o, 64, 64);
    end
  end

  // Compare every cycle on the falling edge, and tally events per instance.
  always @(negedge iclk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d outputs @%0t", i, $time), 128'(act[i]), 128'(mr[i].o));
      n_out[i] <= n_out[i] + int'(act[i].v);
      n_ns[i]  <= n_ns[i] + int'(act[i].ens);
      n_sip[i] <= n_sip[i] + int'(act[i].esip);
      n_ov[i]  <= n_ov[i] + int'(act[i].eov);
      n_rt[i]  <= n_rt[i] + int'(act[i].ert);
      n_bp[i]  <= n_bp[i] + int'(act[i].e && act[i].b);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic send(input logic sop, input logic eop, input logic [1:0] res,
                      input logic [31:0] d, input logic err);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_residual = res;
    in_data = d; in_err = err;
    @(posedge iclk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_residual = 2'd0;
    in_data = 32'd0; in_err = 1'b0;
  endtask

  // n beats; SOP on beat 0 and on sop_beat; err on err_beat; idle gap after gap_beat.
  task automatic send_pkt(input int n, input logic [1:0] res, input int err_beat,
                          input int sop_beat, input int gap_beat);
    for (int i = 0; i < n; i++) begin
      send((i == 0) || (i == sop_beat), i == n - 1, (i == n - 1) ? res : 2'd0,
           32'hC0DE_0000 ^ (32'(n) << 8) ^ 32'(i), i == err_beat);
      if (i == gap_beat) idle(2);
    end
    idle(2);
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      s_out[i] = n_out[i]; s_ns[i] = n_ns[i]; s_sip[i] = n_sip[i];
      s_ov[i] = n_ov[i]; s_rt[i] = n_rt[i]; s_bp[i] = n_bp[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_out[i] = 0; n_ns[i] = 0; n_sip[i] = 0; n_ov[i] = 0; n_rt[i] = 0; n_bp[i] = 0;
    end
    idle(3);
    check("reset u0 outputs", 128'(act[0]), 128'd0);
    check("reset u1 outputs", 128'(act[1]), 128'd0);
    irst = 1'b0;
    idle(2);

    // 17 beats, residual 2 = 66 bytes: clean on u0, oversize on final beat of u1.
    snap();
    send_pkt(17, 2'd2, -1, -1, -1);
    check("pkt66 u0 beats", n_out[0] - s_out[0], 17);
    check("pkt66 u0 bad", n_bp[0] - s_bp[0], 0);
    check("pkt66 u0 pkt_cnt", stat_pkt_cnt[0], 16'd1);
    check("pkt66 u1 beats", n_out[1] - s_out[1], 17);
    check("pkt66 u1 oversize", n_ov[1] - s_ov[1], 1);

    // Exactly 64 bytes: neither runt nor oversize on u1.
    snap();
    send_pkt(16, 2'd0, -1, -1, -1);
    check("pkt64 u1 bad", n_bp[1] - s_bp[1], 0);
    check("pkt64 u1 oversize", n_ov[1] - s_ov[1], 0);

    // 2-beat runt.
    snap();
    send_pkt(2, 2'd0, -1, -1, -1);
    check("runt u0 beats", n_out[0] - s_out[0], 2);
    check("runt u0 err_runt", n_rt[0] - s_rt[0], 1);
    check("runt u0 bad_cnt", stat_bad_cnt[0], 16'd1);
    check("runt u0 pkt_cnt", stat_pkt_cnt[0], 16'd3);

    // 20 beats = 80 bytes: u1 truncates at beat 16, drops 17..19.
    snap();
    send_pkt(20, 2'd0, -1, -1, -1);
    check("pkt80 u1 beats", n_out[1] - s_out[1], 17);
    check("pkt80 u1 oversize", n_ov[1] - s_ov[1], 1);
    check("pkt80 u0 beats", n_out[0] - s_out[0], 20);

    // Orphan beats, then a clean packet.
    snap();
    send(1'b0, 1'b0, 2'd0, 32'h0BAD_0001, 1'b0);
    send(1'b0, 1'b0, 2'd0, 32'h0BAD_0002, 1'b0);
    send(1'b0, 1'b1, 2'd3, 32'h0BAD_0003, 1'b0);
    send_pkt(17, 2'd2, -1, -1, -1);
    check("orphan u0 no_sop", n_ns[0] - s_ns[0], 1);
    check("orphan u0 beats", n_out[0] - s_out[0], 17);
    check("orphan u0 bad", n_bp[0] - s_bp[0], 0);

    // SOP on beat 3 of an open 7-beat packet.
    snap();
    send_pkt(7, 2'd0, -1, 3, -1);
    check("sop_in_pkt u0 beats", n_out[0] - s_out[0], 4);
    check("sop_in_pkt u0 pulse", n_sip[0] - s_sip[0], 1);
    check("sop_in_pkt u0 bad", n_bp[0] - s_bp[0], 1);

    // PHY error mid-packet with an idle gap inside the packet.
    snap();
    send_pkt(17, 2'd1, 5, -1, 8);
    check("phy_err u0 beats", n_out[0] - s_out[0], 17);
    check("phy_err u0 bad", n_bp[0] - s_bp[0], 1);

    // Reset in the middle of a packet.
    send(1'b1, 1'b0, 2'd0, 32'h1111_0000, 1'b0);
    send(1'b0, 1'b0, 2'd0, 32'h1111_0001, 1'b0);
    in_valid = 1'b1; in_data = 32'h1111_0002;
    irst = 1'b1;
    @(negedge iclk);
    check("midrst u0 outputs", 128'(act[0]), 128'd0);
    check("midrst u1 outputs", 128'(act[1]), 128'd0);
    in_valid = 1'b0; in_data = 32'd0;
    idle(2);
    irst = 1'b0;
    idle(1);
    snap();
    send(1'b0, 1'b0, 2'd0, 32'h2222_0000, 1'b0);
    send(1'b0, 1'b1, 2'd0, 32'h2222_0001, 1'b0);
    idle(2);
    check("postrst u0 no_sop", n_ns[0] - s_ns[0], 1);
    check("postrst u0 beats", n_out[0] - s_out[0], 0);

    // Saturation: 0xFFFF+2 single-beat runts.
    for (int i = 0; i < 32'h1_0001; i++) begin
      send(1'b1, 1'b1, 2'd0, 32'(i), 1'b0);
    end
    idle(2);
    check("sat u0 bad_cnt", stat_bad_cnt[0], 16'hFFFF);
    check("sat u0 pkt_cnt", stat_pkt_cnt[0], 16'hFFFF);
    check("sat u1 bad_cnt", stat_bad_cnt[1], 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
